// File: rtl/dht11_report_pkg.sv
// Shared constants and types for the DHT11 text reporter: ASCII codes, FSM states,
// line-template slot indices and digit helpers.
package dht11_report_pkg;

   localparam logic [7:0] ASC_H   = 8'h48;
   localparam logic [7:0] ASC_T   = 8'h54;
   localparam logic [7:0] ASC_EQ  = 8'h3D;
   localparam logic [7:0] ASC_DOT = 8'h2E;
   localparam logic [7:0] ASC_SP  = 8'h20;
   localparam logic [7:0] ASC_CR  = 8'h0D;
   localparam logic [7:0] ASC_LF  = 8'h0A;
   localparam logic [7:0] ASC_0   = 8'h30;

   localparam int CONV_LEN = 8;

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   typedef struct packed {
      logic [7:0] humInt;
      logic [7:0] humDec;
      logic [7:0] tempInt;
      logic [7:0] tempDec;
   } meas_t;

   localparam int SLOT_W    = 5;
   localparam int NUM_SLOTS = 17;
   typedef logic [SLOT_W-1:0] slot_t;

   // "H=hhh.d T=ttt.d" CR LF, one slot per possible character
   localparam slot_t SLOT_H    = 5'd0;
   localparam slot_t SLOT_EQ1  = 5'd1;
   localparam slot_t SLOT_HH   = 5'd2;
   localparam slot_t SLOT_HT   = 5'd3;
   localparam slot_t SLOT_HU   = 5'd4;
   localparam slot_t SLOT_HDOT = 5'd5;
   localparam slot_t SLOT_HDEC = 5'd6;
   localparam slot_t SLOT_SP   = 5'd7;
   localparam slot_t SLOT_T    = 5'd8;
   localparam slot_t SLOT_EQ2  = 5'd9;
   localparam slot_t SLOT_TH   = 5'd10;
   localparam slot_t SLOT_TT   = 5'd11;
   localparam slot_t SLOT_TU   = 5'd12;
   localparam slot_t SLOT_TDOT = 5'd13;
   localparam slot_t SLOT_TDEC = 5'd14;
   localparam slot_t SLOT_CR   = 5'd15;
   localparam slot_t SLOT_LF   = 5'd16;

   function automatic logic [7:0] digitChar(input logic [3:0] d);
      return ASC_0 + {4'b0000, d};
   endfunction

   function automatic logic [7:0] decChar(input logic [7:0] d);
      return (d > 8'd9) ? ASC_0 + 8'd9 : ASC_0 + d;
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble, 8 bits to three BCD digits. iStart loads the operand,
// eight shift cycles follow; oDone is high in the last shift cycle, digits hold afterwards.
module bin2bcd8
   import dht11_report_pkg::*;
(
   input  logic       iClk,
   input  logic       iRstn,
   input  logic       iStart,
   input  logic [7:0] iBin,
   output logic [3:0] oHund,
   output logic [3:0] oTens,
   output logic [3:0] oOnes,
   output logic       oDone
);

   logic [11:0] bcd;
   logic [11:0] bcdAdj;
   logic [7:0]  sh;
   logic [3:0]  cnt;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_comb bcdAdj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         bcd <= '0;
         sh  <= '0;
         cnt <= 4'(CONV_LEN);
      end else if (iStart) begin
         bcd <= '0;
         sh  <= iBin;
         cnt <= '0;
      end else if (cnt != 4'(CONV_LEN)) begin
         {bcd, sh} <= {bcdAdj, sh} << 1;
         cnt       <= cnt + 4'd1;
      end
   end

   assign oHund = bcd[11:8];
   assign oTens = bcd[7:4];
   assign oOnes = bcd[3:0];
   assign oDone = (cnt == 4'(CONV_LEN - 1));

endmodule

// File: rtl/dht11_uart_reporter.sv
// Formats each DHT11 measurement as "H=44.0 T=23.0" CR LF and streams it over valid/ready.
// First byte 9 cycles after the strobe; holds each byte until accepted, one-deep pending slot.
module dht11_uart_reporter
   import dht11_report_pkg::*;
#(
   parameter bit EN_DECIMAL = 1'b1,
   parameter bit TERM_CRLF  = 1'b1
) (
   input  logic       iClk,
   input  logic       iRstn,
   input  logic       iEnable,
   input  logic       iDhtDataValid,
   input  logic [7:0] iHumInt,
   input  logic [7:0] iHumDec,
   input  logic [7:0] iTempInt,
   input  logic [7:0] iTempDec,
   output logic [7:0] oTxData,
   output logic       oTxValid,
   input  logic       iTxReady,
   output logic       oBusy,
   output logic       oDropped
);

   state_t state, stateNext;
   meas_t  strobeMeas, pend, capNext;
   logic   pendVld, dropPulse;
   logic [7:0] capHumDec, capTempDec;
   slot_t  slot, slotNext;
   logic [NUM_SLOTS-1:0] slotEn;
   logic   stb, accept, finalAcc, loadCap;
   logic [3:0] humH, humT, humO, tempH, tempT, tempO;
   logic   humDone, tempDone;

   assign stb        = iEnable && iDhtDataValid;
   assign strobeMeas = '{humInt: iHumInt, humDec: iHumDec, tempInt: iTempInt, tempDec: iTempDec};
   assign accept     = (state == SEND) && iTxReady;
   assign finalAcc   = accept && (slot == SLOT_LF);
   // A strobe landing on the final accept is newer than anything pending, so it is served next
   assign loadCap    = ((state == IDLE) && stb) || (finalAcc && (stb || pendVld));
   assign capNext    = stb ? strobeMeas : pend;

   bin2bcd8 uHumBcd (
      .iClk(iClk), .iRstn(iRstn), .iStart(loadCap), .iBin(capNext.humInt),
      .oHund(humH), .oTens(humT), .oOnes(humO), .oDone(humDone)
   );

   bin2bcd8 uTempBcd (
      .iClk(iClk), .iRstn(iRstn), .iStart(loadCap), .iBin(capNext.tempInt),
      .oHund(tempH), .oTens(tempT), .oOnes(tempO), .oDone(tempDone)
   );

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         capHumDec  <= '0;
         capTempDec <= '0;
      end else if (loadCap) begin
         capHumDec  <= capNext.humDec;
         capTempDec <= capNext.tempDec;
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         pend      <= '0;
         pendVld   <= 1'b0;
         dropPulse <= 1'b0;
      end else begin
         dropPulse <= 1'b0;
         if (finalAcc) begin
            pendVld   <= 1'b0;
            dropPulse <= stb && pendVld;
         end else if (stb && (state != IDLE)) begin
            pend      <= strobeMeas;
            pendVld   <= 1'b1;
            dropPulse <= pendVld;
         end
      end
   end

   always_comb begin
      slotEn            = '1;
      slotEn[SLOT_HH]   = (humH != 4'd0);
      slotEn[SLOT_HT]   = (humH != 4'd0) || (humT != 4'd0);
      slotEn[SLOT_TH]   = (tempH != 4'd0);
      slotEn[SLOT_TT]   = (tempH != 4'd0) || (tempT != 4'd0);
      slotEn[SLOT_HDOT] = EN_DECIMAL;
      slotEn[SLOT_HDEC] = EN_DECIMAL;
      slotEn[SLOT_TDOT] = EN_DECIMAL;
      slotEn[SLOT_TDEC] = EN_DECIMAL;
      slotEn[SLOT_CR]   = TERM_CRLF;
   end

   // Lowest enabled slot above the current one; LF is always enabled so it is the fallback
   always_comb begin
      slotNext = SLOT_LF;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if ((i > int'(slot)) && slotEn[i]) slotNext = slot_t'(i);
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn)               slot <= SLOT_H;
      else if (state != SEND)   slot <= SLOT_H;
      else if (accept)          slot <= slotNext;
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (stb) stateNext = CONV;
         CONV:    if (humDone && tempDone) stateNext = SEND;
         SEND:    if (finalAcc) stateNext = loadCap ? CONV : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      oTxValid = (state == SEND);
      oBusy    = (state != IDLE);
      oDropped = dropPulse;
      oTxData  = 8'h00;
      if (state == SEND) begin
         case (slot)
            SLOT_H:             oTxData = ASC_H;
            SLOT_T:             oTxData = ASC_T;
            SLOT_EQ1, SLOT_EQ2: oTxData = ASC_EQ;
            SLOT_HDOT, SLOT_TDOT: oTxData = ASC_DOT;
            SLOT_SP:            oTxData = ASC_SP;
            SLOT_HH:            oTxData = digitChar(humH);
            SLOT_HT:            oTxData = digitChar(humT);
            SLOT_HU:            oTxData = digitChar(humO);
            SLOT_HDEC:          oTxData = decChar(capHumDec);
            SLOT_TH:            oTxData = digitChar(tempH);
            SLOT_TT:            oTxData = digitChar(tempT);
            SLOT_TU:            oTxData = digitChar(tempO);
            SLOT_TDEC:          oTxData = decChar(capTempDec);
            SLOT_CR:            oTxData = ASC_CR;
            SLOT_LF:            oTxData = ASC_LF;
            default:            oTxData = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Directed bench for dht11_uart_reporter: a default instance plus a no-decimal, LF-only instance,
// with every received byte compared against hand-written expected lines.
module tb_dht11_uart_reporter;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic en1 = 1'b0, en2 = 1'b0, dv = 1'b0;
   logic txReady = 1'b1, randRdy = 1'b0;
   logic [7:0] humInt = '0, humDec = '0, tempInt = '0, tempDec = '0;
   logic [7:0] txData1, txData2;
   logic txValid1, txValid2, busy1, busy2, drop1, drop2;

   int nChecks = 0, nFails = 0, dropCnt = 0;
   logic [7:0] rx1[$], rx2[$];
   logic prevVld = 1'b0, prevRdy = 1'b0;
   logic [7:0] prevDat = '0;

   always #5 clk = ~clk;

   dht11_uart_reporter dut1 (
      .iClk(clk), .iRstn(rstn), .iEnable(en1), .iDhtDataValid(dv),
      .iHumInt(humInt), .iHumDec(humDec), .iTempInt(tempInt), .iTempDec(tempDec),
      .oTxData(txData1), .oTxValid(txValid1), .iTxReady(txReady),
      .oBusy(busy1), .oDropped(drop1)
   );

   dht11_uart_reporter #(.EN_DECIMAL(1'b0), .TERM_CRLF(1'b0)) dut2 (
      .iClk(clk), .iRstn(rstn), .iEnable(en2), .iDhtDataValid(dv),
      .iHumInt(humInt), .iHumDec(humDec), .iTempInt(tempInt), .iTempDec(tempDec),
      .oTxData(txData2), .oTxValid(txValid2), .iTxReady(txReady),
      .oBusy(busy2), .oDropped(drop2)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge
   always @(negedge clk) begin
      if (rstn) begin
         if (prevVld && !prevRdy) begin
            checkVal("stall valid held", {31'b0, txValid1}, 1);
            checkVal("stall data held", {24'b0, txData1}, {24'b0, prevDat});
         end
         if (txValid1 && txReady) rx1.push_back(txData1);
         if (txValid2 && txReady) rx2.push_back(txData2);
         if (drop1 || drop2) dropCnt <= dropCnt + 1;
         prevVld <= txValid1;
      end else begin
         prevVld <= 1'b0;
      end
      prevRdy <= txReady;
      prevDat <= txData1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (randRdy) txReady = 1'($urandom_range(0, 1));
   endtask

   task automatic strobe(input logic [7:0] h, input logic [7:0] hd, input logic [7:0] t, input logic [7:0] td);
      humInt = h; humDec = hd; tempInt = t; tempDec = td;
      dv = 1'b1;
      tick();
      dv = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input bit second);
      int n = 0;
      while (((second ? busy2 : busy1) == 1'b1) && (n < 3000)) begin
         tick();
         n++;
      end
      checkVal({tag, " idle"}, {31'b0, second ? busy2 : busy1}, 0);
   endtask

   // Pops one line from the chosen receive queue; a missing byte reads as 0x100
   task automatic checkLine(input string tag, input string body, input bit crlf, input bit second);
      int total = body.len() + (crlf ? 2 : 1);
      logic [8:0] got;
      logic [7:0] e;
      for (int i = 0; i < total; i++) begin
         if (i < body.len())              e = body[i];
         else if (crlf && i == body.len()) e = 8'h0D;
         else                              e = 8'h0A;
         if (second) got = (rx2.size() > 0) ? {1'b0, rx2.pop_front()} : 9'h100;
         else        got = (rx1.size() > 0) ? {1'b0, rx1.pop_front()} : 9'h100;
         checkVal($sformatf("%s byte%0d", tag, i), {23'b0, got}, {24'b0, e});
      end
   endtask

   initial begin
      int n;
      #1;
      checkVal("reset txData", {24'b0, txData1}, 0);
      checkVal("reset txValid", {31'b0, txValid1}, 0);
      checkVal("reset busy", {31'b0, busy1}, 0);
      checkVal("reset dropped", {31'b0, drop1}, 0);
      tick();
      rstn = 1'b1;
      tick();
      tick();
      en1 = 1'b1;

      // 44.0 / 23.0 with ready held high: latency and back-to-back bytes
      strobe(8'd44, 8'd0, 8'd23, 8'd0);
      checkVal("busy after strobe", {31'b0, busy1}, 1);
      checkVal("no valid during conv", {31'b0, txValid1}, 0);
      n = 0;
      while (!txValid1 && n < 50) begin
         tick();
         n++;
      end
      checkVal("first valid latency", n + 1, 9);
      checkVal("first byte H", {24'b0, txData1}, 32'h48);
      repeat (14) tick();
      checkVal("LF presented", {24'b0, txData1}, 32'h0A);
      checkVal("busy during LF", {31'b0, busy1}, 1);
      tick();
      checkVal("busy low after LF", {31'b0, busy1}, 0);
      checkLine("L44", "H=44.0 T=23.0", 1'b1, 1'b0);
      checkVal("rx1 empty L44", rx1.size(), 0);

      // single digits, zero, three digits and decimal clamp
      strobe(8'd5, 8'd0, 8'd0, 8'd0);
      waitIdle("L5", 1'b0);
      strobe(8'd255, 8'd12, 8'd100, 8'd0);
      waitIdle("L255", 1'b0);
      checkLine("L5", "H=5.0 T=0.0", 1'b1, 1'b0);
      checkLine("L255", "H=255.9 T=100.0", 1'b1, 1'b0);

      // pseudo-random backpressure
      randRdy = 1'b1;
      strobe(8'd44, 8'd0, 8'd23, 8'd0);
      waitIdle("Lrand", 1'b0);
      randRdy = 1'b0;
      txReady = 1'b1;
      checkLine("Lrand", "H=44.0 T=23.0", 1'b1, 1'b0);

      // two strobes during a line: the newer one wins, one drop pulse
      strobe(8'd44, 8'd0, 8'd23, 8'd0);
      repeat (3) tick();
      strobe(8'd51, 8'd0, 8'd26, 8'd0);
      checkVal("no drop first pending", {31'b0, drop1}, 0);
      repeat (2) tick();
      strobe(8'd60, 8'd0, 8'd30, 8'd0);
      checkVal("drop pulse", {31'b0, drop1}, 1);
      tick();
      checkVal("drop one cycle", {31'b0, drop1}, 0);
      waitIdle("Ldrop", 1'b0);
      checkLine("Ldrop1", "H=44.0 T=23.0", 1'b1, 1'b0);
      checkLine("Ldrop2", "H=60.0 T=30.0", 1'b1, 1'b0);
      checkVal("rx1 empty drop", rx1.size(), 0);
      checkVal("drop count", dropCnt, 1);

      // no-decimal LF-only variant, then strobes with enable low
      en1 = 1'b0;
      en2 = 1'b1;
      strobe(8'd44, 8'd0, 8'd23, 8'd0);
      waitIdle("Lnodec", 1'b1);
      checkLine("Lnodec", "H=44 T=23", 1'b0, 1'b1);
      en2 = 1'b0;
      strobe(8'd51, 8'd0, 8'd26, 8'd0);
      checkVal("disabled busy1", {31'b0, busy1}, 0);
      checkVal("disabled busy2", {31'b0, busy2}, 0);
      repeat (20) tick();
      checkVal("disabled rx1", rx1.size(), 0);
      checkVal("disabled rx2", rx2.size(), 0);
      en1 = 1'b1;

      // reset after the sixth byte
      strobe(8'd44, 8'd0, 8'd23, 8'd0);
      n = 0;
      while (rx1.size() < 6 && n < 100) begin
         tick();
         n++;
      end
      checkVal("six bytes before reset", rx1.size(), 6);
      rstn = 1'b0;
      #1;
      checkVal("mid reset txValid", {31'b0, txValid1}, 0);
      checkVal("mid reset txData", {24'b0, txData1}, 0);
      checkVal("mid reset busy", {31'b0, busy1}, 0);
      checkVal("mid reset dropped", {31'b0, drop1}, 0);
      rx1.delete();
      repeat (2) tick();
      rstn = 1'b1;
      repeat (20) tick();
      checkVal("no partial line", rx1.size(), 0);
      strobe(8'd51, 8'd0, 8'd26, 8'd0);
      waitIdle("Lrst", 1'b0);
      checkLine("Lrst", "H=51.0 T=26.0", 1'b1, 1'b0);
      checkVal("total drops", dropCnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
      $finish;
   end

endmodule
